// File: rtl/key_event_decoder.sv
// Key level to PRESS/RELEASE/LONG/REPEAT event decoder feeding a FWFT event FIFO.
// Optional build macro: KEY_EVENT_REPEAT_EN enables periodic REPEAT events while long-held.
module key_event_decoder #(
  parameter bit          pActiveLow          = 1'b1,
  parameter int unsigned pClockDividerFactor = 1000000,
  parameter int unsigned pLongPressTicks     = 100,
  parameter int unsigned pRepeatTicks        = 20,
  parameter int unsigned pFifoDepth          = 4
) (
  input  logic                          iwClk,
  input  logic                          iwnRst,
  input  logic                          iwKeyLevel,
  input  logic                          iwEventReady,
  output logic                          orEventValid,
  output logic [1:0]                    orEventCode,
  output logic [$clog2(pFifoDepth):0]   orEventCount,
  output logic                          orOverflow,
  input  logic                          iwClrOverflow,
  output logic                          orKeyHeld
);

  localparam int unsigned AW = $clog2(pFifoDepth);
  localparam int unsigned CW = AW + 1;
  localparam logic [31:0]   DIV_LAST   = 32'(pClockDividerFactor - 1);
  localparam logic [31:0]   LONG_T     = 32'(pLongPressTicks);
  localparam logic [CW-1:0] FULL_COUNT = CW'(pFifoDepth);

  typedef enum logic [1:0] {IDLE, PRESSED, LONGHELD} state_t;
  typedef enum logic [1:0] {
    EV_PRESS   = 2'b00,
    EV_RELEASE = 2'b01,
    EV_LONG    = 2'b10,
    EV_REPEAT  = 2'b11
  } event_t;

  state_t      state, state_nxt;
  logic [31:0] presc, presc_nxt;
  logic [31:0] hold, hold_nxt, hold_inc;
  logic        pressed;
  logic        push;
  event_t      push_code;

  logic [1:0]    mem [pFifoDepth];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, pop, wr_en, drop, overflow;

  assign pressed  = iwKeyLevel ^ pActiveLow;
  assign hold_inc = (hold == '1) ? hold : hold + 32'd1;

  always_ff @(posedge iwClk or negedge iwnRst) begin
    if (!iwnRst) begin
      state <= IDLE;
      presc <= '0;
      hold  <= '0;
    end else begin
      state <= state_nxt;
      presc <= presc_nxt;
      hold  <= hold_nxt;
    end
  end

  // Release is checked first in every held state so it pre-empts a LONG/REPEAT on the same edge.
  always_comb begin
    state_nxt = state;
    presc_nxt = presc;
    hold_nxt  = hold;
    push      = 1'b0;
    push_code = EV_PRESS;
    unique case (state)
      IDLE: begin
        if (pressed) begin
          state_nxt = PRESSED;
          push      = 1'b1;
          push_code = EV_PRESS;
          presc_nxt = '0;
          hold_nxt  = '0;
        end
      end
      PRESSED: begin
        if (!pressed) begin
          state_nxt = IDLE;
          push      = 1'b1;
          push_code = EV_RELEASE;
          presc_nxt = '0;
          hold_nxt  = '0;
        end else if (presc == DIV_LAST) begin
          presc_nxt = '0;
          if (hold_inc == LONG_T) begin
            state_nxt = LONGHELD;
            push      = 1'b1;
            push_code = EV_LONG;
            hold_nxt  = '0;
          end else begin
            hold_nxt = hold_inc;
          end
        end else begin
          presc_nxt = presc + 32'd1;
        end
      end
      LONGHELD: begin
        if (!pressed) begin
          state_nxt = IDLE;
          push      = 1'b1;
          push_code = EV_RELEASE;
          presc_nxt = '0;
          hold_nxt  = '0;
        end
`ifdef KEY_EVENT_REPEAT_EN
        else if (presc == DIV_LAST) begin
          presc_nxt = '0;
          if (hold_inc == 32'(pRepeatTicks)) begin
            push      = 1'b1;
            push_code = EV_REPEAT;
            hold_nxt  = '0;
          end else begin
            hold_nxt = hold_inc;
          end
        end else begin
          presc_nxt = presc + 32'd1;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign full  = (count == FULL_COUNT);
  assign pop   = (count != '0) && iwEventReady;
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  always_ff @(posedge iwClk) begin
    if (wr_en) mem[wr_ptr] <= push_code;
  end

  always_ff @(posedge iwClk or negedge iwnRst) begin
    if (!iwnRst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      unique case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
      if (drop)               overflow <= 1'b1;
      else if (iwClrOverflow) overflow <= 1'b0;
    end
  end

  // Head is gated so the stale, unreset storage never shows while empty.
  assign orEventValid = (count != '0);
  assign orEventCode  = orEventValid ? mem[rd_ptr] : 2'b00;
  assign orEventCount = count;
  assign orOverflow   = overflow;
  assign orKeyHeld    = (state != IDLE);

endmodule

// File: tb/tb_key_event_decoder.sv
// Self-checking bench for key_event_decoder: vector table, directed corner sequences,
// and a randomized run against an event-timing reference model.
module tb_key_event_decoder;

  localparam int F     = 4;
  localparam int L     = 3;
  localparam int R     = 2;
  localparam int DEPTH = 4;
  localparam int LONG_CLK = L * F;
  localparam int REP_CLK  = R * F;
`ifdef KEY_EVENT_REPEAT_EN
  localparam bit REP_ON = 1'b1;
`else
  localparam bit REP_ON = 1'b0;
`endif

  logic       clk, rst_n;
  logic       level, ready, clr_ovf;
  logic       valid, ovf, held;
  logic [1:0] code;
  logic [2:0] count;
  logic       level2, ready2;
  logic       valid2, ovf2, held2;
  logic [1:0] code2;
  logic [2:0] count2;

  key_event_decoder #(.pActiveLow(1'b1), .pClockDividerFactor(F), .pLongPressTicks(L),
                      .pRepeatTicks(R), .pFifoDepth(DEPTH)) dut (
    .iwClk(clk), .iwnRst(rst_n), .iwKeyLevel(level), .iwEventReady(ready),
    .orEventValid(valid), .orEventCode(code), .orEventCount(count),
    .orOverflow(ovf), .iwClrOverflow(clr_ovf), .orKeyHeld(held));

  key_event_decoder #(.pActiveLow(1'b0), .pClockDividerFactor(F), .pLongPressTicks(L),
                      .pRepeatTicks(R), .pFifoDepth(DEPTH)) dut_hi (
    .iwClk(clk), .iwnRst(rst_n), .iwKeyLevel(level2), .iwEventReady(ready2),
    .orEventValid(valid2), .orEventCode(code2), .orEventCount(count2),
    .orOverflow(ovf2), .iwClrOverflow(1'b0), .orKeyHeld(held2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: event timing from press age in clocks, FIFO as a queue.
  logic [1:0] q[$];
  bit m_held;
  int m_age;
  bit m_ovf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_held = 1'b0;
    m_age  = 0;
    m_ovf  = 1'b0;
  endtask

  task automatic model_edge(input logic lvl, input logic rdy, input logic clr);
    bit pr, have_ev, popped, dropped;
    logic [1:0] ev;
    pr = (lvl == 1'b0);
    have_ev = 1'b0;
    ev = 2'b00;
    if (!m_held && pr) begin
      have_ev = 1'b1; ev = 2'b00; m_held = 1'b1; m_age = 0;
    end else if (m_held && !pr) begin
      have_ev = 1'b1; ev = 2'b01; m_held = 1'b0;
    end else if (m_held) begin
      m_age++;
      if (m_age == LONG_CLK) begin
        have_ev = 1'b1; ev = 2'b10;
      end else if (REP_ON && m_age > LONG_CLK && ((m_age - LONG_CLK) % REP_CLK) == 0) begin
        have_ev = 1'b1; ev = 2'b11;
      end
    end
    popped = (q.size() > 0) && rdy;
    if (popped) void'(q.pop_front());
    dropped = 1'b0;
    if (have_ev) begin
      if (q.size() < DEPTH) q.push_back(ev);
      else dropped = 1'b1;
    end
    if (dropped) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endtask

  task automatic check_model();
    logic [1:0] head;
    head = (q.size() > 0) ? q[0] : 2'b00;
    check("model_valid", 32'(valid), 32'(q.size() > 0));
    check("model_code",  32'(code),  32'(head));
    check("model_count", 32'(count), 32'(q.size()));
    check("model_ovf",   32'(ovf),   32'(m_ovf));
    check("model_held",  32'(held),  32'(m_held));
  endtask

  task automatic apply(input logic lvl, input logic rdy, input logic clr);
    level = lvl; ready = rdy; clr_ovf = clr;
    @(posedge clk);
    model_edge(lvl, rdy, clr);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_valid", 32'(valid), 0);
    check("rst_code",  32'(code),  0);
    check("rst_count", 32'(count), 0);
    check("rst_ovf",   32'(ovf),   0);
    check("rst_held",  32'(held),  0);
    check("rst_count2", 32'(count2), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic lvl, rdy, clr;
    logic v; logic [1:0] c; logic [2:0] n; logic o, h;
  } vec_t;
  vec_t tbl[10];

  logic [1:0] exp_codes[4];

  initial begin
    int seg;
    int expc;
    int ndrain;
    logic lv, rd;

    rst_n = 1'b0; level = 1'b1; ready = 1'b0; clr_ovf = 1'b0;
    level2 = 1'b0; ready2 = 1'b0;
    exp_codes[0] = 2'b00; exp_codes[1] = 2'b10; exp_codes[2] = 2'b11; exp_codes[3] = 2'b11;

    tbl[0] = '{1'b1,1'b0,1'b0, 1'b0,2'b00,3'd0,1'b0,1'b0};
    tbl[1] = '{1'b0,1'b0,1'b0, 1'b1,2'b00,3'd1,1'b0,1'b1};
    tbl[2] = '{1'b0,1'b0,1'b0, 1'b1,2'b00,3'd1,1'b0,1'b1};
    tbl[3] = '{1'b0,1'b0,1'b0, 1'b1,2'b00,3'd1,1'b0,1'b1};
    tbl[4] = '{1'b0,1'b0,1'b0, 1'b1,2'b00,3'd1,1'b0,1'b1};
    tbl[5] = '{1'b0,1'b0,1'b0, 1'b1,2'b00,3'd1,1'b0,1'b1};
    tbl[6] = '{1'b1,1'b0,1'b0, 1'b1,2'b00,3'd2,1'b0,1'b0};
    tbl[7] = '{1'b1,1'b1,1'b0, 1'b1,2'b01,3'd1,1'b0,1'b0};
    tbl[8] = '{1'b1,1'b1,1'b0, 1'b0,2'b00,3'd0,1'b0,1'b0};
    tbl[9] = '{1'b1,1'b1,1'b0, 1'b0,2'b00,3'd0,1'b0,1'b0};

    // Short press: PRESS, RELEASE after 5 held edges, then drain.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      apply(tbl[i].lvl, tbl[i].rdy, tbl[i].clr);
      check($sformatf("vec%0d_valid", i), 32'(valid), 32'(tbl[i].v));
      check($sformatf("vec%0d_code", i),  32'(code),  32'(tbl[i].c));
      check($sformatf("vec%0d_count", i), 32'(count), 32'(tbl[i].n));
      check($sformatf("vec%0d_ovf", i),   32'(ovf),   32'(tbl[i].o));
      check($sformatf("vec%0d_held", i),  32'(held),  32'(tbl[i].h));
    end

    // Long hold: LONG 12 clocks after PRESS, REPEAT every 8 clocks when enabled.
    do_reset();
    for (int i = 1; i <= 30; i++) begin
      apply(1'b0, 1'b0, 1'b0);
      expc = 1 + int'(i >= 13) + int'(REP_ON) * (int'(i >= 21) + int'(i >= 29));
      check($sformatf("hold_count_%0d", i), 32'(count), 32'(expc));
    end
    ndrain = REP_ON ? 4 : 2;
    for (int k = 0; k < ndrain; k++) begin
      check($sformatf("hold_code_%0d", k), 32'(code), 32'(exp_codes[k]));
      apply(1'b0, 1'b1, 1'b0);
    end
    check("hold_drained", 32'(count), 0);
    apply(1'b1, 1'b0, 1'b0);
    check("hold_release_code", 32'(code), 1);
    apply(1'b1, 1'b1, 1'b0);

    // Overflow: five events into a 4-deep FIFO, clear, drain in order.
    do_reset();
    apply(1'b0, 1'b0, 1'b0);
    apply(1'b1, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 1'b0);
    apply(1'b1, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 1'b0);
    check("ovf_count", 32'(count), 4);
    check("ovf_set",   32'(ovf),   1);
    apply(1'b1, 1'b0, 1'b0);
    check("ovf_sticky", 32'(ovf), 1);
    apply(1'b1, 1'b0, 1'b1);
    check("ovf_clear", 32'(ovf), 0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("ovf_drain_%0d", k), 32'(code), 32'(k % 2));
      apply(1'b1, 1'b1, 1'b0);
    end
    check("ovf_empty", 32'(count), 0);

    // Push while full with a simultaneous pop.
    do_reset();
    apply(1'b0, 1'b0, 1'b0);
    apply(1'b1, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 1'b0);
    apply(1'b1, 1'b0, 1'b0);
    apply(1'b0, 1'b1, 1'b0);
    check("fullpop_count", 32'(count), 4);
    check("fullpop_ovf",   32'(ovf),   0);
    check("fullpop_head",  32'(code),  1);
    repeat (6) apply(1'b1, 1'b1, 1'b0);

    // Reset while long-held: PRESS again after release, no RELEASE.
    do_reset();
    repeat (16) apply(1'b0, 1'b0, 1'b0);
    check("lh_held", 32'(held), 1);
    do_reset();
    apply(1'b0, 1'b0, 1'b0);
    check("rh_count", 32'(count), 1);
    check("rh_code",  32'(code),  0);
    check("rh_held",  32'(held),  1);
    repeat (3) apply(1'b0, 1'b0, 1'b0);
    check("rh_norelease", 32'(count), 1);
    apply(1'b1, 1'b1, 1'b0);
    apply(1'b1, 1'b1, 1'b0);

    // Active-high instance.
    do_reset();
    level2 = 1'b0; ready2 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      apply(1'b1, 1'b1, 1'b0);
      check($sformatf("hi_idle_%0d", i), 32'(count2), 0);
    end
    level2 = 1'b1;
    apply(1'b1, 1'b1, 1'b0);
    check("hi_press_count", 32'(count2), 1);
    check("hi_press_code",  32'(code2),  0);
    check("hi_press_held",  32'(held2),  1);
    level2 = 1'b0;
    apply(1'b1, 1'b1, 1'b0);
    check("hi_release_count", 32'(count2), 2);
    check("hi_release_held",  32'(held2),  0);
    ready2 = 1'b1;
    apply(1'b1, 1'b1, 1'b0);
    check("hi_pop_code",  32'(code2),  1);
    check("hi_pop_count", 32'(count2), 1);
    ready2 = 1'b0;

    // Randomized run against the model, with one reset mid-run.
    do_reset();
    seg = 0;
    lv = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) do_reset();
      if (seg == 0) begin
        lv = ~lv;
        seg = $urandom_range(1, 40);
      end
      seg--;
      rd = ($urandom_range(0, 7) < ((c / 300) % 4) * 2 + 1);
      apply(lv, rd, $urandom_range(0, 31) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
